// File: rtl/store_fwd_buffer_pkg.sv
// +----------------------------------------------------------------------+
// | store_fwd_buffer_pkg : shared dcache store-buffer types and helpers  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package store_fwd_buffer_pkg;

    localparam int SFB_ADDR_W = 32;
    localparam int SFB_DATA_W = 32;
    localparam int SFB_BYTES  = SFB_DATA_W / 8;

    typedef struct packed {
        logic [SFB_ADDR_W-1:0] addr;
        logic [SFB_DATA_W-1:0] data;
        logic [SFB_BYTES-1:0]  strb;
        logic                  uncached;
    } sfb_entry_t;

    // Pointers carry one extra wrap bit above the index.
    function automatic int sfb_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int sfb_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sfb_fwd_lookup.sv
// +----------------------------------------------------------------------+
// | sfb_fwd_lookup : per-byte youngest-match forwarding for one load port|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sfb_fwd_lookup
    import store_fwd_buffer_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = SFB_ADDR_W,
    parameter  int DATA_W = SFB_DATA_W,
    localparam int BYTES  = sfb_bytes(DATA_W),
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]             ld_addr,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  ent_data,
    input  logic [DEPTH-1:0][BYTES-1:0]   ent_strb,
    input  logic [DEPTH-1:0]              ent_uncached,
    input  logic [DEPTH-1:0]              ent_occ,
    input  logic [IDX_W-1:0]              head_idx,
    output logic [BYTES-1:0]              fwd_mask,
    output logic [DATA_W-1:0]             fwd_data,
    output logic                          conflict
);

    localparam int c_OFF = $clog2(BYTES);

    // Byte-offset bits take no part in the word compare.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{ld_addr, ent_addr};

    // Walk oldest to youngest so a later hit overrides an earlier one.
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic             hit;
        fwd_mask = '0;
        fwd_data = '0;
        conflict = 1'b0;
        idx      = '0;
        hit      = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_idx + IDX_W'(k);
            hit = ent_occ[idx] &&
                  (ent_addr[idx][ADDR_W-1:c_OFF] == ld_addr[ADDR_W-1:c_OFF]);
            if (hit && ent_uncached[idx]) begin
                conflict = 1'b1;
            end
            for (int b = 0; b < BYTES; b++) begin
                if (hit && !ent_uncached[idx] && ent_strb[idx][b]) begin
                    fwd_mask[b]        = 1'b1;
                    fwd_data[8*b +: 8] = ent_data[idx][8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_fwd_buffer.sv
// +----------------------------------------------------------------------+
// | store_fwd_buffer : M1 store buffer with commit, drain and forwarding |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module store_fwd_buffer
    import store_fwd_buffer_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  int ADDR_W   = SFB_ADDR_W,
    parameter  int DATA_W   = SFB_DATA_W,
    parameter  int LD_PORTS = 2,
    localparam int BYTES    = sfb_bytes(DATA_W),
    localparam int PTR_W    = sfb_ptr_w(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enq_valid_i,
    output logic                              enq_ready_o,
    input  logic [ADDR_W-1:0]                 enq_addr_i,
    input  logic [DATA_W-1:0]                 enq_data_i,
    input  logic [BYTES-1:0]                  enq_strb_i,
    input  logic                              enq_uncached_i,
    input  logic                              commit_i,
    input  logic                              flush_i,
    output logic                              drn_valid_o,
    input  logic                              drn_ready_i,
    output logic [ADDR_W-1:0]                 drn_addr_o,
    output logic [DATA_W-1:0]                 drn_data_o,
    output logic [BYTES-1:0]                  drn_strb_o,
    output logic                              drn_uncached_o,
    input  logic [LD_PORTS-1:0][ADDR_W-1:0]   ld_addr_i,
    output logic [LD_PORTS-1:0][BYTES-1:0]    ld_fwd_mask_o,
    output logic [LD_PORTS-1:0][DATA_W-1:0]   ld_fwd_data_o,
    output logic [LD_PORTS-1:0]               ld_conflict_o,
    output logic [PTR_W-1:0]                  count_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_cmt;
    logic [PTR_W-1:0]             r_tail;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [DEPTH-1:0][BYTES-1:0]  r_strb;
    logic [DEPTH-1:0]             r_unc;

    logic [PTR_W-1:0] w_count;
    logic             w_full;
    logic             w_enq;
    logic             w_cmt;
    logic             w_drn;
    logic [PTR_W-1:0] w_cmt_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [DEPTH-1:0] w_occ;

    assign w_count = r_tail - r_head;
    assign w_full  = (w_count == PTR_W'(DEPTH));

    assign enq_ready_o = !w_full && !rst;
    assign drn_valid_o = (r_head != r_cmt) && !rst;
    assign count_o     = w_count;
    assign full_o      = w_full;
    assign empty_o     = (w_count == '0);

    assign w_enq = enq_valid_i && enq_ready_o && !flush_i;
    assign w_cmt = commit_i && (r_cmt != r_tail);
    assign w_drn = drn_valid_o && drn_ready_i;

    // Flush truncates to the post-commit boundary, so a same-cycle commit survives.
    assign w_cmt_nxt  = r_cmt + PTR_W'(w_cmt);
    assign w_tail_nxt = flush_i ? w_cmt_nxt : r_tail + PTR_W'(w_enq);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + PTR_W'(w_drn);
            r_cmt  <= w_cmt_nxt;
            r_tail <= w_tail_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail[IDX_W-1:0]] <= enq_addr_i;
            r_data[r_tail[IDX_W-1:0]] <= enq_data_i;
            r_strb[r_tail[IDX_W-1:0]] <= enq_strb_i;
            r_unc[r_tail[IDX_W-1:0]]  <= enq_uncached_i;
        end
    end

    assign drn_addr_o     = r_addr[r_head[IDX_W-1:0]];
    assign drn_data_o     = r_data[r_head[IDX_W-1:0]];
    assign drn_strb_o     = r_strb[r_head[IDX_W-1:0]];
    assign drn_uncached_o = r_unc[r_head[IDX_W-1:0]];

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ[i] = ({1'b0, IDX_W'(i) - r_head[IDX_W-1:0]} < w_count);
        end
    end

    for (genvar p = 0; p < LD_PORTS; p++) begin : g_port
        sfb_fwd_lookup #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_lookup (
            .ld_addr      (ld_addr_i[p]),
            .ent_addr     (r_addr),
            .ent_data     (r_data),
            .ent_strb     (r_strb),
            .ent_uncached (r_unc),
            .ent_occ      (w_occ),
            .head_idx     (r_head[IDX_W-1:0]),
            .fwd_mask     (ld_fwd_mask_o[p]),
            .fwd_data     (ld_fwd_data_o[p]),
            .conflict     (ld_conflict_o[p])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_store_fwd_buffer.sv
// +----------------------------------------------------------------------+
// | tb_store_fwd_buffer : directed + random bench with a queue model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_store_fwd_buffer;
    import store_fwd_buffer_pkg::*;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int LD_PORTS = 2;
    localparam int BYTES    = 4;
    localparam int PTR_W    = 3;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            enq_valid_i;
    logic                            enq_ready_o;
    logic [ADDR_W-1:0]               enq_addr_i;
    logic [DATA_W-1:0]               enq_data_i;
    logic [BYTES-1:0]                enq_strb_i;
    logic                            enq_uncached_i;
    logic                            commit_i;
    logic                            flush_i;
    logic                            drn_valid_o;
    logic                            drn_ready_i;
    logic [ADDR_W-1:0]               drn_addr_o;
    logic [DATA_W-1:0]               drn_data_o;
    logic [BYTES-1:0]                drn_strb_o;
    logic                            drn_uncached_o;
    logic [LD_PORTS-1:0][ADDR_W-1:0] ld_addr_i;
    logic [LD_PORTS-1:0][BYTES-1:0]  ld_fwd_mask_o;
    logic [LD_PORTS-1:0][DATA_W-1:0] ld_fwd_data_o;
    logic [LD_PORTS-1:0]             ld_conflict_o;
    logic [PTR_W-1:0]                count_o;
    logic                            full_o;
    logic                            empty_o;

    always #5 clk = ~clk;

    store_fwd_buffer #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LD_PORTS (LD_PORTS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enq_valid_i    (enq_valid_i),
        .enq_ready_o    (enq_ready_o),
        .enq_addr_i     (enq_addr_i),
        .enq_data_i     (enq_data_i),
        .enq_strb_i     (enq_strb_i),
        .enq_uncached_i (enq_uncached_i),
        .commit_i       (commit_i),
        .flush_i        (flush_i),
        .drn_valid_o    (drn_valid_o),
        .drn_ready_i    (drn_ready_i),
        .drn_addr_o     (drn_addr_o),
        .drn_data_o     (drn_data_o),
        .drn_strb_o     (drn_strb_o),
        .drn_uncached_o (drn_uncached_o),
        .ld_addr_i      (ld_addr_i),
        .ld_fwd_mask_o  (ld_fwd_mask_o),
        .ld_fwd_data_o  (ld_fwd_data_o),
        .ld_conflict_o  (ld_conflict_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o)
    );

    // Reference: queue in age order; the first ncmt entries are committed.
    sfb_entry_t q[$];
    int         ncmt  = 0;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [BYTES-1:0]  m;
        logic [DATA_W-1:0] d;
        logic              c;
        if (rst) begin
            chk("enq_ready_in_rst", 64'(enq_ready_o), 64'd0);
            chk("drn_valid_in_rst", 64'(drn_valid_o), 64'd0);
            return;
        end
        chk("count", 64'(count_o), 64'(q.size()));
        chk("full", 64'(full_o), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty_o), 64'(q.size() == 0));
        chk("enq_ready", 64'(enq_ready_o), 64'(q.size() < DEPTH));
        chk("drn_valid", 64'(drn_valid_o), 64'(ncmt > 0));
        if (ncmt > 0) begin
            chk("drn_addr", 64'(drn_addr_o), 64'(q[0].addr));
            chk("drn_data", 64'(drn_data_o), 64'(q[0].data));
            chk("drn_strb", 64'(drn_strb_o), 64'(q[0].strb));
            chk("drn_uncached", 64'(drn_uncached_o), 64'(q[0].uncached));
        end
        for (int p = 0; p < LD_PORTS; p++) begin
            m = '0;
            d = '0;
            c = 1'b0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].addr[ADDR_W-1:2] == ld_addr_i[p][ADDR_W-1:2]) begin
                    if (q[i].uncached) begin
                        c = 1'b1;
                    end else begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (q[i].strb[b]) begin
                                m[b]        = 1'b1;
                                d[8*b +: 8] = q[i].data[8*b +: 8];
                            end
                        end
                    end
                end
            end
            chk("fwd_mask", 64'(ld_fwd_mask_o[p]), 64'(m));
            chk("fwd_data", 64'(ld_fwd_data_o[p]), 64'(d));
            chk("conflict", 64'(ld_conflict_o[p]), 64'(c));
        end
    endtask

    task automatic model_update();
        bit do_enq;
        bit do_cmt;
        bit do_drn;
        if (rst) begin
            q.delete();
            ncmt = 0;
            return;
        end
        do_enq = enq_valid_i && (q.size() < DEPTH) && !flush_i;
        do_cmt = commit_i && (q.size() > ncmt);
        do_drn = (ncmt > 0) && drn_ready_i;
        if (do_cmt) ncmt++;
        if (do_drn) begin
            void'(q.pop_front());
            ncmt--;
        end
        if (flush_i) begin
            while (q.size() > ncmt) void'(q.pop_back());
        end
        if (do_enq) q.push_back('{enq_addr_i, enq_data_i, enq_strb_i, enq_uncached_i});
    endtask

    task automatic step();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0; drn_ready_i = 1'b0;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic u);
        enq_valid_i = 1'b1; enq_addr_i = a; enq_data_i = d; enq_strb_i = s; enq_uncached_i = u;
    endtask

    task automatic drain_all();
        idle();
        commit_i    = 1'b1;
        drn_ready_i = 1'b1;
        repeat (2*DEPTH + 2) step();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        enq_addr_i = '0; enq_data_i = '0; enq_strb_i = '0; enq_uncached_i = 1'b0;
        ld_addr_i  = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_empty", 64'(empty_o), 64'd1);
        chk("reset_full", 64'(full_o), 64'd0);
        chk("reset_drn_valid", 64'(drn_valid_o), 64'd0);
        chk("reset_enq_ready", 64'(enq_ready_o), 64'd1);

        // Fill to full, nothing drainable before commit.
        enq(32'h100, 32'hAABBCCDD, 4'hF, 1'b0); step();
        enq(32'h104, 32'h01020304, 4'hF, 1'b0); step();
        enq(32'h108, 32'h05060708, 4'hF, 1'b0); step();
        enq(32'h10C, 32'h090A0B0C, 4'hF, 1'b0); step();
        idle();
        chk("fill_full", 64'(full_o), 64'd1);
        chk("fill_ready", 64'(enq_ready_o), 64'd0);
        chk("fill_count", 64'(count_o), 64'd4);
        chk("fill_no_drain", 64'(drn_valid_o), 64'd0);
        commit_i = 1'b1;
        repeat (4) step();
        idle();
        // Full with a same-cycle drain still refuses the enqueue.
        enq(32'h110, 32'h11111111, 4'hF, 1'b0);
        drn_ready_i = 1'b1;
        step();
        step();
        drain_all();

        // Byte-granular youngest-wins forwarding.
        enq(32'h200, 32'h00001111, 4'h3, 1'b0); step();
        enq(32'h200, 32'h00002200, 4'h2, 1'b0); step();
        idle();
        ld_addr_i[0] = 32'h200;
        ld_addr_i[1] = 32'h204;
        #1;
        chk("fwd_p0_mask", 64'(ld_fwd_mask_o[0]), 64'h3);
        chk("fwd_p0_data", 64'(ld_fwd_data_o[0]), 64'h00002211);
        chk("fwd_p1_mask", 64'(ld_fwd_mask_o[1]), 64'h0);
        step();
        drain_all();

        // Flush with a concurrent commit keeps the newly committed entry.
        enq(32'h500, 32'hA0A0A0A0, 4'hF, 1'b0); step();
        enq(32'h504, 32'hB0B0B0B0, 4'hF, 1'b0); step();
        enq(32'h508, 32'hC0C0C0C0, 4'hF, 1'b0); step();
        idle();
        commit_i = 1'b1; step();
        flush_i  = 1'b1; step();
        idle();
        chk("flush_count", 64'(count_o), 64'd2);
        drn_ready_i = 1'b1;
        #1;
        chk("flush_drain0", 64'(drn_addr_o), 64'h500);
        step();
        chk("flush_drain1", 64'(drn_addr_o), 64'h504);
        step();
        chk("flush_empty", 64'(empty_o), 64'd1);
        idle();

        // Uncached word raises conflict and is never forwarded.
        enq(32'h300, 32'hDEADBEEF, 4'hF, 1'b1); step();
        idle();
        ld_addr_i[1] = 32'h302;
        #1;
        chk("unc_conflict", 64'(ld_conflict_o[1]), 64'd1);
        chk("unc_mask", 64'(ld_fwd_mask_o[1]), 64'd0);
        step();
        flush_i = 1'b1; step();
        idle();
        chk("unc_flushed", 64'(empty_o), 64'd1);

        // Random traffic across several pointer wraps.
        for (int n = 0; n < 200; n++) begin
            enq_valid_i    = 1'($urandom_range(0, 1));
            enq_addr_i     = 32'h400 + 32'($urandom_range(0, 31));
            enq_data_i     = $urandom;
            enq_strb_i     = 4'($urandom_range(0, 15));
            enq_uncached_i = ($urandom_range(0, 7) == 0);
            commit_i       = 1'($urandom_range(0, 1));
            drn_ready_i    = 1'($urandom_range(0, 1));
            flush_i        = ($urandom_range(0, 15) == 0);
            ld_addr_i[0]   = 32'h400 + 32'($urandom_range(0, 31));
            ld_addr_i[1]   = 32'h400 + 32'($urandom_range(0, 31));
            step();
        end
        drain_all();

        // Reset mid-operation loses committed entries.
        enq(32'h600, 32'h12345678, 4'hF, 1'b0); step();
        enq(32'h604, 32'h9ABCDEF0, 4'hF, 1'b0); step();
        idle();
        commit_i = 1'b1; step(); step();
        idle();
        rst = 1'b1; step();
        rst = 1'b0;
        #1;
        chk("rst_mid_count", 64'(count_o), 64'd0);
        chk("rst_mid_drn_valid", 64'(drn_valid_o), 64'd0);
        chk("rst_mid_enq_ready", 64'(enq_ready_o), 64'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_fwd_buffer.md
# store_fwd_buffer

Parametrised store buffer with byte-granular store-to-load forwarding, for the dcache M1 stage. It holds speculative stores written by M1 until commit marks them retired. It drains committed stores in order to the cache write port. It discards uncommitted stores on flush and serves LD_PORTS concurrent load lookups.

## Interface
- DEPTH, 4: entry count; power of two, ≥2
- ADDR_W, 32: physical address width
- DATA_W, 32: store word width; multiple of 8; BYTES = DATA_W/8
- LD_PORTS, 2: number of independent forwarding query ports
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enq_valid_i / enq_ready_o  in/out  1  M1 store enqueue handshake
- enq_addr_i  in  ADDR_W  store physical address
- enq_data_i  in  DATA_W  store data, byte lanes aligned
- enq_strb_i  in  BYTES  byte write enables
- enq_uncached_i  in  1  store targets uncached space
- commit_i  in  1  retire oldest uncommitted entry
- flush_i  in  1  discard all uncommitted entries
- drn_valid_o / drn_ready_i  out/in  1  drain handshake to cache/bus
- drn_addr_o, drn_data_o, drn_strb_o, drn_uncached_o  out  ADDR_W/DATA_W/BYTES/1  oldest committed entry
- ld_addr_i  in  LD_PORTS×ADDR_W  load physical address per port
- ld_fwd_mask_o  out  LD_PORTS×BYTES  bytes supplied by buffer
- ld_fwd_data_o  out  LD_PORTS×DATA_W  forwarded bytes; other lanes zero
- ld_conflict_o  out  LD_PORTS  word matches an uncached entry
- count_o  out  $clog2(DEPTH)+1  occupied entries
- full_o, empty_o  out  1  status

## Operation
- Circular array with three pointers, each $clog2(DEPTH)+1 bits; MSB is the wrap bit.
  - head: oldest entry.
  - cmt: oldest uncommitted entry.
  - tail: next free slot.
  - Pointer invariant: head ≤ cmt ≤ tail.
- Entry regions: committed is [head, cmt); speculative is [cmt, tail).
- Enqueue occurs on enq_valid_i & enq_ready_o & !flush_i. enq_ready_o = !full_o & !rst.
- Enqueue with enq_strb_i == 0 is accepted and stored. It is drained with a zero strobe.
- commit_i with cmt ≠ tail advances cmt by 1. commit_i with cmt == tail is ignored.
- flush_i sets tail ← cmt after that cycle's commit is applied. An entry committed in the flush cycle survives.
- Drain presents entry[head] when head ≠ cmt. head advances on drn_valid_o & drn_ready_i.
- Forwarding per port p compares word addresses: addr[ADDR_W-1:$clog2(BYTES)].
  - For each byte b, pick the youngest occupied entry (committed or speculative) that matches the word and has strb[b] set.
  - Entries with uncached = 1 are never forwarded. Any uncached word match sets ld_conflict_o[p].
- count_o = tail − head (modular). full_o = (count_o == DEPTH). empty_o = (count_o == 0).

## Timing
- Reset values: all pointers 0, enq_ready_o 0 while rst, drn_valid_o 0, ld_fwd_mask_o 0, ld_conflict_o 0, count_o 0, empty_o 1, full_o 0.
- Reset is taken mid-operation: all entries are lost, including committed ones.
- Latency:
  - Enqueued entry is visible to forwarding and count_o the cycle after acceptance.
  - Committed entry is drainable the cycle after commit_i.
  - Forwarding outputs are combinational from ld_addr_i and the registered state.
- Full: enq_ready_o stays 0 even if a drain fires the same cycle. There is no same-cycle pass-through.
- Simultaneous enqueue, commit and drain in one cycle are all applied. tail, cmt and head each move by 1.
- Flush with enqueue: the enqueue is dropped. Flush with drain: the drain proceeds.
- Wrap-around: full is detected when the tail and head indices are equal and their wrap bits differ.
- drn_* payload is stable while drn_valid_o & !drn_ready_i. The flush guarantee rests on the pointer invariant: flush never moves head or cmt.

## Structure
- Shared package (dcache package):
  - sfb_entry_t {addr, data, strb, uncached}.
  - Pointer-width helper constant.
  - BYTES localparam convention.
- Sub-module sfb_fwd_lookup, instantiated LD_PORTS times.
  - Inputs: entry array, occupancy vector, age order from head. Output: per-byte youngest-match mux.
  - The top level keeps pointers, handshakes and storage.

## Test plan
- Enqueue 4 stores with DEPTH=4 (0x100/0xAABBCCDD/strb 0xF, then 0x104, 0x108, 0x10C) -> full_o=1, enq_ready_o=0, count_o=4; drn_valid_o=0 until commit.
- Enqueue 0x200 strb 0x3 data 0x1111 then 0x200 strb 0x2 data 0x2200, query port 0 at 0x200 -> mask 0x3, data 0x00002211; port 1 at 0x204 -> mask 0.
- Enqueue 3, commit 1, assert flush_i together with a second commit -> count_o=2, drain returns exactly those 2 entries in order, then empty_o=1.
- Uncached store at 0x300; load port 1 queries 0x302 -> ld_conflict_o[1]=1, mask 0.
- Run 3×DEPTH enqueue/commit/drain with random drn_ready_i -> drained order equals enqueue order across pointer wrap; payload held while stalled.
- Assert rst with 2 committed entries -> next cycle count_o=0, drn_valid_o=0; enq_ready_o=1 the cycle after rst drops.
